// File: rtl/ecu_gpio_pkg.sv
// -----------------------------------------------------------------------------
// ecu_gpio_pkg
// Shared definitions for the ECU GPIO bank responder: register word addresses,
// the register selector enum and the byteenable-to-bitmask helper.
// -----------------------------------------------------------------------------
package ecu_gpio_pkg;

    localparam logic [2:0] ADDR_IN   = 3'd0;
    localparam logic [2:0] ADDR_OUT  = 3'd1;
    localparam logic [2:0] ADDR_SET  = 3'd2;
    localparam logic [2:0] ADDR_CLR  = 3'd3;
    localparam logic [2:0] ADDR_EDGE = 3'd4;
    localparam logic [2:0] ADDR_MASK = 3'd5;
    localparam logic [2:0] ADDR_POL  = 3'd6;
    localparam logic [2:0] ADDR_RSVD = 3'd7;

    typedef enum logic [2:0] {
        REG_IN   = ADDR_IN,
        REG_OUT  = ADDR_OUT,
        REG_SET  = ADDR_SET,
        REG_CLR  = ADDR_CLR,
        REG_EDGE = ADDR_EDGE,
        REG_MASK = ADDR_MASK,
        REG_POL  = ADDR_POL,
        REG_RSVD = ADDR_RSVD
    } ecu_gpio_reg_e;

    // Expand the four byte lanes into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ecu_gpio_sync.sv
// -----------------------------------------------------------------------------
// ecu_gpio_sync
// WIDTH x SYNC_STAGES flop chain bringing asynchronous pins into clk.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset, clears every stage
//   d     - asynchronous input bits
//   q     - last synchronizer stage
// -----------------------------------------------------------------------------
module ecu_gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage 0 sits in the low WIDTH bits; the oldest stage in the top bits.
    logic [SYNC_STAGES*WIDTH-1:0] chain_r;

    // Shift the pins through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[(SYNC_STAGES-1)*WIDTH-1:0], d};
        end
    end

    assign q = chain_r[SYNC_STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/ecu_gpio_responder.sv
// -----------------------------------------------------------------------------
// ecu_gpio_responder
// Avalon-MM slave for one ECU GPIO bank: direct-write OUT register with atomic
// SET/CLR aliases, synchronized IN port, per-bit polarity-selected edge capture
// (write-1-to-clear) and a maskable level interrupt. Fixed read latency of 1.
// Ports:
//   clk_clk, reset_reset_n  - clock, synchronous active-low reset
//   avs_address/read/write  - word address and one-cycle transfer strobes
//   avs_writedata/byteenable- write data and byte lanes
//   avs_readdata/valid      - registered read response, one cycle after read
//   gpio_in                 - asynchronous input pins
//   gpio_out                - output pins (OUT register)
//   irq                     - registered OR of EDGE & MASK
// -----------------------------------------------------------------------------
module ecu_gpio_responder
    import ecu_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic             irq
);

    localparam logic [31:0] WIDTH_MASK =
        (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

    ecu_gpio_reg_e    reg_sel_s;
    logic [31:0]      wr_mask32_s;
    logic [WIDTH-1:0] wr_bits_s;
    logic [WIDTH-1:0] wdata_s;

    logic [WIDTH-1:0] sync_in_s;
    logic [WIDTH-1:0] in_dly_r;
    logic             armed_r;
    logic [WIDTH-1:0] capture_s;

    logic [WIDTH-1:0] out_r,  out_next_s;
    logic [WIDTH-1:0] edge_r, edge_next_s;
    logic [WIDTH-1:0] mask_r, mask_next_s;
    logic [WIDTH-1:0] pol_r,  pol_next_s;
    logic [WIDTH-1:0] w1c_s;
    logic             irq_r;

    logic [31:0]      rd_word_s;
    logic [31:0]      rdata_r;
    logic             rvalid_r;

    assign reg_sel_s   = ecu_gpio_reg_e'(avs_address);
    assign wr_mask32_s = be_to_mask(avs_byteenable) & WIDTH_MASK;
    assign wr_bits_s   = wr_mask32_s[WIDTH-1:0];
    assign wdata_s     = avs_writedata[WIDTH-1:0];

    ecu_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     (gpio_in),
        .q     (sync_in_s)
    );

    // Edge detection: compare synchronized pins against last cycle's copy,
    // suppressed on the first cycle after reset while the copy is loaded.
    always_comb begin
        capture_s = '0;
        if (armed_r) begin
            capture_s = (sync_in_s & ~in_dly_r & pol_r) |
                        (~sync_in_s & in_dly_r & ~pol_r);
        end else begin
            capture_s = '0;
        end
    end

    // Register write decode; a fresh capture overrides a same-cycle W1C.
    always_comb begin
        out_next_s  = out_r;
        mask_next_s = mask_r;
        pol_next_s  = pol_r;
        w1c_s       = '0;
        if (avs_write) begin
            case (reg_sel_s)
                REG_OUT:  out_next_s  = (out_r & ~wr_bits_s) | (wdata_s & wr_bits_s);
                REG_SET:  out_next_s  = out_r | (wdata_s & wr_bits_s);
                REG_CLR:  out_next_s  = out_r & ~(wdata_s & wr_bits_s);
                REG_EDGE: w1c_s       = wdata_s & wr_bits_s;
                REG_MASK: mask_next_s = (mask_r & ~wr_bits_s) | (wdata_s & wr_bits_s);
                REG_POL:  pol_next_s  = (pol_r & ~wr_bits_s) | (wdata_s & wr_bits_s);
                default:  w1c_s       = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
        edge_next_s = (edge_r & ~w1c_s) | capture_s;
    end

    // Read mux; write-only and reserved words read as zero.
    always_comb begin
        rd_word_s = 32'd0;
        case (reg_sel_s)
            REG_IN:   rd_word_s[WIDTH-1:0] = sync_in_s;
            REG_OUT:  rd_word_s[WIDTH-1:0] = out_r;
            REG_EDGE: rd_word_s[WIDTH-1:0] = edge_r;
            REG_MASK: rd_word_s[WIDTH-1:0] = mask_r;
            REG_POL:  rd_word_s[WIDTH-1:0] = pol_r;
            default:  rd_word_s = 32'd0;
        endcase
    end

    // Control/status registers and the edge-detect delayed copy.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            out_r    <= '0;
            edge_r   <= '0;
            mask_r   <= '0;
            pol_r    <= '0;
            in_dly_r <= '0;
            armed_r  <= 1'b0;
        end else begin
            out_r    <= out_next_s;
            edge_r   <= edge_next_s;
            mask_r   <= mask_next_s;
            pol_r    <= pol_next_s;
            in_dly_r <= sync_in_s;
            armed_r  <= 1'b1;
        end
    end

    // Interrupt flop, one cycle behind the EDGE/MASK registers.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(edge_r & mask_r);
        end
    end

    // Read response: data sampled before any same-cycle write takes effect.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= avs_read;
            if (avs_read) begin
                rdata_r <= rd_word_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign gpio_out          = out_r;
    assign irq               = irq_r;
    assign avs_readdata      = rdata_r;
    assign avs_readdatavalid = rvalid_r;

endmodule
